// File: rtl/calc_input_ctrl_pkg.sv
// Shared definitions for the calculator input front-end: op encodings, widths,
// FSM state type and the captured operand payload.
package calc_input_ctrl_pkg;

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned OPND_W   = 4;
   localparam int unsigned NUM_BTN  = 4;
   localparam int unsigned DB_CNT_W = 20;

   localparam logic [OPND_W-1:0] OP_CONCAT = 4'b0000;
   localparam logic [OPND_W-1:0] OP_ADD    = 4'b0001;
   localparam logic [OPND_W-1:0] OP_SUB    = 4'b0010;
   localparam logic [OPND_W-1:0] OP_MUL    = 4'b0100;
   localparam logic [OPND_W-1:0] OP_RSVD   = 4'b1000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [OPND_W-1:0] op;
      logic [OPND_W-1:0] data1;
      logic [OPND_W-1:0] data2;
   } calc_operands_t;

   // True when exactly one button is down, i.e. the vector is a legal op code
   function automatic logic is_single_op(input logic [OPND_W-1:0] v);
      return (v == OP_ADD) || (v == OP_SUB) || (v == OP_MUL) || (v == OP_RSVD);
   endfunction

endpackage

// File: rtl/calc_input_ctrl_btn_debounce.sv
// One pushbutton: 2-FF synchronizer followed by a stable-level debouncer that
// flips only after DEBOUNCE_CYCLES consecutive differing samples.
module calc_input_ctrl_btn_debounce
   import calc_input_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_pi,
   input  logic reset_pi,
   input  logic raw_pi,
   output logic level_po
);

   localparam logic [DB_CNT_W-1:0] LAST_CNT = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                meta;
   logic                sync;
   logic [DB_CNT_W-1:0] cnt;

   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         meta     <= 1'b0;
         sync     <= 1'b0;
         level_po <= 1'b0;
         cnt      <= '0;
      end else begin
         meta <= raw_pi;
         sync <= meta;
         // Any sample matching the stable level restarts the count
         if (sync == level_po) begin
            cnt <= '0;
         end else if (cnt == LAST_CNT) begin
            level_po <= ~level_po;
            cnt      <= '0;
         end else begin
            cnt <= cnt + DB_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator input front-end: debounced buttons select a one-hot op, switches
// supply the operands, all latched per accepted press; plus a free-running counter.
module calc_input_ctrl
   import calc_input_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic              clk_pi,
   input  logic              reset_pi,
   input  logic [3:0]        btn_pi,
   input  logic [7:0]        sw_pi,
   output logic [3:0]        data1_po,
   output logic [3:0]        data2_po,
   output logic [3:0]        op_po,
   output logic              op_strobe_po,
   output logic [15:0]       counter_po
);

   logic [7:0]         sw_meta;
   logic [7:0]         sw_sync;
   logic [NUM_BTN-1:0] db;
   state_t             state;
   calc_operands_t     latched;
   logic [CNT_W-1:0]   counter;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      calc_input_ctrl_btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_pi   (clk_pi),
         .reset_pi (reset_pi),
         .raw_pi   (btn_pi[i]),
         .level_po (db[i])
      );
   end

   // Switch sync, press FSM, operand capture and cycle counter
   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         sw_meta      <= '0;
         sw_sync      <= '0;
         state        <= ST_IDLE;
         latched      <= '{op: OP_CONCAT, data1: '0, data2: '0};
         op_strobe_po <= 1'b0;
         counter      <= '0;
      end else begin
         sw_meta      <= sw_pi;
         sw_sync      <= sw_meta;
         counter      <= counter + CNT_W'(1);
         op_strobe_po <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Multi-button presses still enter HOLD so they cannot re-trigger
               if (db != '0) begin
                  state <= ST_HOLD;
                  if (is_single_op(db)) begin
                     latched      <= '{op: db, data1: sw_sync[7:4], data2: sw_sync[3:0]};
                     op_strobe_po <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (db == '0) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign op_po      = latched.op;
   assign data1_po   = latched.data1;
   assign data2_po   = latched.data2;
   assign counter_po = counter;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Bench for calc_input_ctrl: directed scenarios plus random button/switch
// traffic, every cycle compared against a behavioural model.
module tb_calc_input_ctrl;

   localparam int D = 4;

   logic        clk_pi;
   logic        reset_pi;
   logic [3:0]  btn_pi;
   logic [7:0]  sw_pi;
   logic [3:0]  data1_po;
   logic [3:0]  data2_po;
   logic [3:0]  op_po;
   logic        op_strobe_po;
   logic [15:0] counter_po;

   int total;
   int bad;

   calc_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk_pi       (clk_pi),
      .reset_pi     (reset_pi),
      .btn_pi       (btn_pi),
      .sw_pi        (sw_pi),
      .data1_po     (data1_po),
      .data2_po     (data2_po),
      .op_po        (op_po),
      .op_strobe_po (op_strobe_po),
      .counter_po   (counter_po)
   );

   initial begin
      clk_pi = 1'b0;
      forever #5 clk_pi = ~clk_pi;
   end

   // Reference model state
   logic [3:0]   m_s1b, m_s2b, m_db;
   logic [7:0]   m_s1s, m_s2s;
   logic [D-1:0] m_hist [4];
   logic         m_hold, m_strobe;
   logic [3:0]   m_op, m_d1, m_d2;
   logic [15:0]  m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Button level accepted once the last D synchronized samples all oppose it
   task automatic model_edge();
      logic [3:0] db_next;
      if (reset_pi) begin
         m_s1b = '0; m_s2b = '0; m_db = '0; m_s1s = '0; m_s2s = '0;
         for (int i = 0; i < 4; i++) m_hist[i] = '0;
         m_hold = 1'b0; m_strobe = 1'b0;
         m_op = '0; m_d1 = '0; m_d2 = '0; m_cnt = '0;
      end else begin
         m_strobe = !m_hold && ($countones(m_db) == 1);
         if (m_strobe) begin
            m_op = m_db;
            m_d1 = m_s2s[7:4];
            m_d2 = m_s2s[3:0];
         end
         m_hold = (m_db != 4'd0);
         db_next = m_db;
         for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][D-2:0], m_s2b[i]};
            if (m_hist[i] == {D{~m_db[i]}}) db_next[i] = ~m_db[i];
         end
         m_db  = db_next;
         m_s2b = m_s1b; m_s1b = btn_pi;
         m_s2s = m_s1s; m_s1s = sw_pi;
         m_cnt = m_cnt + 16'd1;
      end
   endtask

   task automatic check_model();
      chk("m_op", 32'(op_po), 32'(m_op));
      chk("m_data1", 32'(data1_po), 32'(m_d1));
      chk("m_data2", 32'(data2_po), 32'(m_d2));
      chk("m_strobe", 32'(op_strobe_po), 32'(m_strobe));
      chk("m_counter", 32'(counter_po), 32'(m_cnt));
   endtask

   task automatic step(input logic [3:0] b, input logic [7:0] s, input logic r);
      btn_pi   = b;
      sw_pi    = s;
      reset_pi = r;
      @(posedge clk_pi);
      model_edge();
      #1;
      check_model();
   endtask

   initial begin
      int          n;
      int unsigned len;
      logic [3:0]  b;
      logic        r;
      total = 0;
      bad   = 0;
      btn_pi = '0; sw_pi = '0; reset_pi = 1'b1;

      // Reset for 3 cycles, then counter runs 0,1,2
      for (int k = 0; k < 3; k++) begin
         step(4'h0, 8'h00, 1'b1);
         chk("rst_op", 32'(op_po), 0);
         chk("rst_data1", 32'(data1_po), 0);
         chk("rst_data2", 32'(data2_po), 0);
         chk("rst_strobe", 32'(op_strobe_po), 0);
         chk("rst_counter", 32'(counter_po), 0);
      end
      step(4'h0, 8'h00, 1'b0);
      chk("rst_counter1", 32'(counter_po), 1);
      step(4'h0, 8'h00, 1'b0);
      chk("rst_counter2", 32'(counter_po), 2);

      // Single press, latched 7 cycles after the raw edge
      n = 0;
      for (int k = 1; k <= 10; k++) begin
         step(4'b0001, 8'h3A, 1'b0);
         n += int'(op_strobe_po);
         if (k == 6) chk("single_pre_op", 32'(op_po), 0);
         if (k == 7) begin
            chk("single_op", 32'(op_po), 32'h1);
            chk("single_data1", 32'(data1_po), 32'h3);
            chk("single_data2", 32'(data2_po), 32'hA);
            chk("single_strobe", 32'(op_strobe_po), 1);
         end
      end
      chk("single_strobe_cnt", n, 1);
      for (int k = 0; k < 10; k++) step(4'h0, 8'h3A, 1'b0);

      // Bounce on button 1 never gets through
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step((k % 2 == 0) ? 4'b0010 : 4'b0000, 8'h66, 1'b0);
         n += int'(op_strobe_po);
      end
      for (int k = 0; k < 10; k++) begin
         step(4'h0, 8'h66, 1'b0);
         n += int'(op_strobe_po);
      end
      chk("bounce_strobe_cnt", n, 0);
      chk("bounce_op", 32'(op_po), 32'h1);

      // Hold with switch change, then rejected two-button press
      for (int k = 0; k < 10; k++) step(4'b0100, 8'h5C, 1'b0);
      chk("hold_op", 32'(op_po), 32'h4);
      for (int k = 0; k < 10; k++) step(4'b0100, 8'hFF, 1'b0);
      chk("hold_data1", 32'(data1_po), 32'h5);
      chk("hold_data2", 32'(data2_po), 32'hC);
      for (int k = 0; k < 10; k++) step(4'h0, 8'hFF, 1'b0);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         step(4'b0011, 8'h12, 1'b0);
         n += int'(op_strobe_po);
      end
      for (int k = 0; k < 10; k++) step(4'h0, 8'h12, 1'b0);
      chk("multi_strobe_cnt", n, 0);
      chk("multi_op", 32'(op_po), 32'h4);
      chk("multi_data1", 32'(data1_po), 32'h5);

      // Reset while held in HOLD, button re-debounced afterwards
      for (int k = 0; k < 10; k++) step(4'b1000, 8'h71, 1'b0);
      chk("rhold_pre_op", 32'(op_po), 32'h8);
      step(4'b1000, 8'h71, 1'b1);
      step(4'b1000, 8'h71, 1'b1);
      chk("rhold_rst_op", 32'(op_po), 0);
      chk("rhold_rst_data1", 32'(data1_po), 0);
      chk("rhold_rst_counter", 32'(counter_po), 0);
      for (int k = 1; k <= 10; k++) begin
         step(4'b1000, 8'h71, 1'b0);
         if (k == 6) chk("rhold_k6_op", 32'(op_po), 0);
         if (k == 7) begin
            chk("rhold_op", 32'(op_po), 32'h8);
            chk("rhold_data1", 32'(data1_po), 32'h7);
            chk("rhold_data2", 32'(data2_po), 32'h1);
            chk("rhold_strobe", 32'(op_strobe_po), 1);
         end
      end
      for (int k = 0; k < 10; k++) step(4'h0, 8'h00, 1'b0);

      // Random traffic against the model
      for (int seg = 0; seg < 250; seg++) begin
         len = $urandom_range(12, 1);
         case ($urandom_range(3, 0))
            0:       b = 4'h0;
            3:       b = 4'($urandom_range(15, 0));
            default: b = 4'(1 << $urandom_range(3, 0));
         endcase
         r = ($urandom_range(39, 0) == 0);
         for (int j = 0; j < int'(len); j++)
            step(b, 8'($urandom), (j == 0) ? r : 1'b0);
      end

      // Counter wrap
      step(4'h0, 8'h00, 1'b1);
      step(4'h0, 8'h00, 1'b1);
      for (int k = 0; k < 65535; k++) step(4'h0, 8'h00, 1'b0);
      chk("wrap_ffff", 32'(counter_po), 32'hFFFF);
      step(4'h0, 8'h00, 1'b0);
      chk("wrap_zero", 32'(counter_po), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_input_ctrl.md
# calc_input_ctrl

Front-end stage for the four-function calculator datapath. It synchronizes and debounces the board pushbuttons and switches, captures the two 4-bit operands and a one-hot operation code on each accepted button press, and holds them stable until the next accepted press. It also supplies the free-running 16-bit counter. All outputs drive the calculator's `data1_pi`, `data2_pi`, `op_pi` and `counter_pi` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples required before a button level is accepted (5 ms at 50 MHz); legal range 1..2^20-1.
- `clk_pi`  in  1  single system clock; all logic is on the rising edge.
- `reset_pi`  in  1  synchronous, active-high reset.
- `btn_pi`  in  4  raw asynchronous pushbuttons, active-high; bit i selects op one-hot `1<<i`.
- `sw_pi`  in  8  raw asynchronous switches; [7:4] = operand1, [3:0] = operand2.
- `data1_po`  out  4  latched operand1.
- `data2_po`  out  4  latched operand2.
- `op_po`  out  4  latched one-hot op code (0000 = concat/idle).
- `op_strobe_po`  out  1  one-cycle pulse in the cycle after new values are latched.
- `counter_po`  out  16  free-running cycle counter.

## Operation
- Synchronization: `btn_pi` and `sw_pi` each pass through a 2-FF synchronizer. Synchronizer flops reset to 0.
- Debounce, per button:
  - Keep a stable level plus a counter.
  - When the synchronized sample differs from the stable level, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
  - Any sample equal to the stable level clears the counter.
  - Result is a 4-bit debounced vector `db`.
- FSM, two states:
  - IDLE: if `db` is nonzero and exactly one bit is set, latch `op_po <= db`, `data1_po <= sw_sync[7:4]` and `data2_po <= sw_sync[3:0]`, then go to HOLD. If `db` has two or more bits set, latch nothing and go to HOLD (rejected press). If `db` is 0, stay in IDLE.
  - HOLD: stay until `db == 0`, then return to IDLE. Press events are ignored in HOLD. Switch changes in HOLD do not alter the outputs.
- `op_strobe_po` is registered from the accept condition, so it is high for exactly one cycle after an accepted latch. A rejected press produces no strobe.
- Counter: `counter_po` increments by 1 every cycle, including during HOLD, and wraps from 0xFFFF to 0x0000.
- Reset values: `data1_po = 0`, `data2_po = 0`, `op_po = 0000`, `op_strobe_po = 0`, `counter_po = 0`, FSM in IDLE, all debounce counters and stable levels at 0.
- Reset asserted mid-debounce or in HOLD: everything returns to reset values on that edge. A button still held after reset must be debounced afresh; it is then accepted as a new press.

## Timing
- Latency from a raw button edge to the debounced edge: 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles.
- Outputs are latched on the edge after `db` becomes one-hot in IDLE. `op_strobe_po` is high during the following cycle.
- The switch value used is the synchronized value present in the accept cycle, i.e. the raw switches from 2 cycles earlier.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `db`.
- Minimum press-to-press spacing is release debounce plus press debounce. There is no re-trigger while a button is held.

## Structure
- Shared include `calc_defs.vh`:
  - op encodings `OP_CONCAT=4'b0000`, `OP_ADD=4'b0001`, `OP_SUB=4'b0010`, `OP_MUL=4'b0100`, `OP_RSVD=4'b1000`
  - the counter width (16) and operand width (4)
  - shared with the calculator.
- Sub-module `btn_debounce`: one synchronizer plus debounce counter per bit, parameterized by `DEBOUNCE_CYCLES`, instantiated 4 times.
- The top level holds the switch synchronizer, the FSM, the output registers and the counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset:
  - Stimulus: hold `reset_pi` for 3 cycles, then release.
  - Required: all outputs 0; `counter_po` reads 0,1,2 on the first three cycles after release.
- Single press:
  - Stimulus: `sw_pi=8'h3A`, `btn_pi=0001` held for 10 cycles.
  - Required: `op_po=0001`, `data1_po=3`, `data2_po=A`, latched 7 cycles after the raw edge; `op_strobe_po` high for exactly 1 cycle.
- Bounce rejection:
  - Stimulus: toggle `btn_pi[1]` with a 2-cycle period for 20 cycles, then release.
  - Required: `op_po` unchanged, no strobe.
- Hold and multi-press:
  - Stimulus: hold `btn_pi=0100` and change `sw_pi` to 8'hFF while held; then release and press `btn_pi=0011`.
  - Required: operands stay at their pre-change values; the `0011` press is rejected with no strobe and `op_po=0100` retained.
- Reset in HOLD:
  - Stimulus: assert reset while `btn_pi=1000` is held, release reset, keep holding.
  - Required: outputs clear, then `op_po=1000` is latched 7 cycles after reset release.
- Counter wrap:
  - Stimulus: run 65536 cycles after reset.
  - Required: `counter_po` reads 0xFFFF and then 0x0000.
